// File: rtl/piece_move_ctrl_pkg.sv
// piece_move_ctrl_pkg: board geometry, controller states, request bits and the wall/floor check
package piece_move_ctrl_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam logic signed [5:0] MAX_COL = 6'(BOARD_W - 1);
  localparam logic signed [5:0] MAX_ROW = 6'(BOARD_H - 1);
  localparam int R_DOWN  = 0;
  localparam int R_RIGHT = 1;
  localparam int R_LEFT  = 2;
  localparam int R_ROT   = 3;
  localparam int R_DROP  = 4;
  typedef enum logic [2:0] {S_EMPTY, S_IDLE, S_CHK, S_SCHK, S_DEAD} state_t;
  function automatic logic out_of_bounds(input logic [3:0] x, input logic [4:0] y, input logic [0:15] m);
    logic signed [5:0] col;
    logic signed [5:0] row;
    out_of_bounds = 1'b0;
    for (int i = 0; i < 16; i++) begin
      col = $signed({2'b00, x}) + $signed({4'b0000, i[1:0]}) - 6'sd3;
      row = $signed({1'b0, y}) + $signed({4'b0000, i[3:2]}) - 6'sd3;
      if (m[i] && (col[5] || col > MAX_COL || row[5] || row > MAX_ROW)) out_of_bounds = 1'b1;
    end
  endfunction
endpackage

// File: rtl/mask_rotate_cw.sv
// mask_rotate_cw: clockwise rotation of a 4x4 piece mask
module mask_rotate_cw (
  input  logic [0:15] mask,
  output logic [0:15] rotated
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign rotated[r*4+c] = mask[(3-c)*4+r];
    end
  end
endmodule

// File: rtl/piece_move_ctrl.sv
// piece_move_ctrl: sequences falling-piece moves through the shared collision checker
module piece_move_ctrl
  import piece_move_ctrl_pkg::*;
#(
  parameter logic [3:0] SPAWN_X = 4'd5,
  parameter logic [4:0] SPAWN_Y = 5'd3,
  parameter int         CHK_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spawn,
  input  logic [0:15] spawn_mask,
  input  logic        req_left,
  input  logic        req_right,
  input  logic        req_rot,
  input  logic        req_down,
  input  logic        req_grav,
  input  logic        req_drop,
  output logic [3:0]  chk_pos_x,
  output logic [4:0]  chk_pos_y,
  output logic [0:15] chk_float,
  input  logic        chk_collision,
  output logic [3:0]  pos_x,
  output logic [4:0]  pos_y,
  output logic [0:15] float,
  output logic        active,
  output logic        busy,
  output logic        lock,
  output logic        game_over
);
  state_t      state, state_n;
  logic [4:0]  pending, pending_n, raw, eff;
  logic [2:0]  op, op_n, sel;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  chk_x_n, pos_x_n;
  logic [4:0]  chk_y_n, pos_y_n;
  logic [0:15] chk_m_n, float_n, rotated;
  logic        lock_n, game_over_n, blocked, wait_done, cancel;

  mask_rotate_cw u_rot (.mask(float), .rotated(rotated));

  assign raw       = pending | {req_drop, req_rot, req_left, req_right, req_down | req_grav};
  assign cancel    = raw[R_LEFT] & raw[R_RIGHT];
  assign eff       = raw & ~{2'b00, cancel, cancel, 1'b0};
  assign sel       = eff[R_DROP] ? 3'(R_DROP) : eff[R_ROT] ? 3'(R_ROT) : eff[R_LEFT] ? 3'(R_LEFT) :
                     eff[R_RIGHT] ? 3'(R_RIGHT) : 3'(R_DOWN);
  assign blocked   = chk_collision | out_of_bounds(chk_pos_x, chk_pos_y, chk_float);
  assign wait_done = cnt == 4'(CHK_LAT);
  assign active    = state == S_IDLE || state == S_CHK;
  assign busy      = state == S_CHK || state == S_SCHK;

  // next-state: dispatch one pending request, wait out the checker, then resolve
  always_comb begin
    state_n = state;
    pending_n = eff;
    op_n = op;
    cnt_n = cnt;
    chk_x_n = chk_pos_x;
    chk_y_n = chk_pos_y;
    chk_m_n = chk_float;
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    float_n = float;
    lock_n = 1'b0;
    game_over_n = game_over;
    case (state)
      S_EMPTY: begin
        pending_n = '0;
        if (spawn) begin
          chk_x_n = SPAWN_X;
          chk_y_n = SPAWN_Y;
          chk_m_n = spawn_mask;
          cnt_n = '0;
          state_n = S_SCHK;
        end
      end
      S_IDLE: if (|eff) begin
        pending_n[sel] = 1'b0;
        op_n = sel;
        cnt_n = '0;
        chk_x_n = sel == 3'(R_LEFT) ? pos_x - 4'd1 : sel == 3'(R_RIGHT) ? pos_x + 4'd1 : pos_x;
        chk_y_n = (sel == 3'(R_DROP) || sel == 3'(R_DOWN)) ? pos_y + 5'd1 : pos_y;
        chk_m_n = sel == 3'(R_ROT) ? rotated : float;
        state_n = S_CHK;
      end
      S_CHK: begin
        if (!wait_done) cnt_n = cnt + 4'd1;
        else if (!blocked) begin
          pos_x_n = chk_pos_x;
          pos_y_n = chk_pos_y;
          float_n = chk_float;
          chk_y_n = op == 3'(R_DROP) ? chk_pos_y + 5'd1 : chk_pos_y;
          cnt_n = '0;
          state_n = op == 3'(R_DROP) ? S_CHK : S_IDLE;
        end else begin
          lock_n = op == 3'(R_DROP) || op == 3'(R_DOWN);
          pending_n = lock_n ? '0 : eff;
          state_n = lock_n ? S_EMPTY : S_IDLE;
        end
      end
      S_SCHK: begin
        if (!wait_done) cnt_n = cnt + 4'd1;
        else if (blocked) begin
          game_over_n = 1'b1;
          state_n = S_DEAD;
        end else begin
          pos_x_n = chk_pos_x;
          pos_y_n = chk_pos_y;
          float_n = chk_float;
          state_n = S_IDLE;
        end
      end
      S_DEAD: pending_n = '0;
      default: state_n = S_EMPTY;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_EMPTY;
      pending <= '0;
      op <= '0;
      cnt <= '0;
      chk_pos_x <= '0;
      chk_pos_y <= '0;
      chk_float <= '0;
      pos_x <= '0;
      pos_y <= '0;
      float <= '0;
      lock <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      op <= op_n;
      cnt <= cnt_n;
      chk_pos_x <= chk_x_n;
      chk_pos_y <= chk_y_n;
      chk_float <= chk_m_n;
      pos_x <= pos_x_n;
      pos_y <= pos_y_n;
      float <= float_n;
      lock <= lock_n;
      game_over <= game_over_n;
    end
endmodule

// File: tb/tb_piece_move_ctrl.sv
// tb_piece_move_ctrl: directed and randomized checks of piece_move_ctrl against a board-level model
module tb_piece_move_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, spawn = 1'b0;
  logic [0:15] spawn_mask = '0;
  logic        req_left = 1'b0, req_right = 1'b0, req_rot = 1'b0;
  logic        req_down = 1'b0, req_grav = 1'b0, req_drop = 1'b0;
  logic        chk_collision = 1'b0;
  logic [3:0]  chk_pos_x, pos_x;
  logic [4:0]  chk_pos_y, pos_y;
  logic [0:15] chk_float, float;
  logic        active, busy, lock, game_over;
  int tests = 0, fails = 0;
  bit board [0:19][0:9];
  int mx = 0, my = 0;
  logic [0:15] mm = '0;
  bit mact = 0;
  logic [0:15] shapes [7] = '{16'h000F, 16'h0066, 16'h00E4, 16'h006C, 16'h00C6, 16'h008E, 16'h002E};

  piece_move_ctrl dut (
    .clk(clk), .rst_n(rst_n), .spawn(spawn), .spawn_mask(spawn_mask),
    .req_left(req_left), .req_right(req_right), .req_rot(req_rot),
    .req_down(req_down), .req_grav(req_grav), .req_drop(req_drop),
    .chk_pos_x(chk_pos_x), .chk_pos_y(chk_pos_y), .chk_float(chk_float),
    .chk_collision(chk_collision), .pos_x(pos_x), .pos_y(pos_y), .float(float),
    .active(active), .busy(busy), .lock(lock), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic bit blocked_at(input int x, input int y, input logic [0:15] m, input bit oob_counts);
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        int c = x - 3 + i % 4;
        int r = y - 3 + i / 4;
        if (c < 0 || c > 9 || r < 0 || r > 19) begin
          if (oob_counts) return 1;
        end else if (board[r][c]) return 1;
      end
    end
    return 0;
  endfunction

  function automatic logic [0:15] rot_cw(input logic [0:15] m);
    logic [0:15] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r*4+c] = m[(3-c)*4+r];
    return o;
  endfunction

  always @(posedge clk) chk_collision <= blocked_at(int'(chk_pos_x), int'(chk_pos_y), chk_float, 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [6:0] r);
    {spawn, req_drop, req_rot, req_left, req_right, req_down, req_grav} = r;
    @(negedge clk);
    {spawn, req_drop, req_rot, req_left, req_right, req_down, req_grav} = '0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        board[r][c] = 0;
  endtask

  task automatic do_spawn(input logic [0:15] m);
    spawn_mask = m;
    pulse(7'b1000000);
    chk("spawn_busy", 32'(busy), 1);
    chk("spawn_inactive_early", 32'(active), 0);
    tick(2);
    mact = 1; mx = 5; my = 3; mm = m;
    chk("spawn_active", 32'(active), 1);
    chk("spawn_x", 32'(pos_x), 32'(mx));
    chk("spawn_y", 32'(pos_y), 32'(my));
    chk("spawn_float", 32'(float), 32'(mm));
  endtask

  task automatic do_move(input int k);
    int nx = mx, ny = my;
    logic [0:15] nm = mm;
    bit ok, down;
    logic [6:0] r;
    down = k == 3;
    if (k == 0) nx--;
    if (k == 1) nx++;
    if (k == 2) nm = rot_cw(mm);
    if (down) ny++;
    ok = !blocked_at(nx, ny, nm, 1);
    r = k == 0 ? 7'b0001000 : k == 1 ? 7'b0000100 : k == 2 ? 7'b0010000 :
        ($urandom_range(0, 1) == 0 ? 7'b0000010 : 7'b0000001);
    pulse(r);
    chk("move_busy", 32'(busy), 1);
    tick(2);
    if (ok) begin mx = nx; my = ny; mm = nm; end
    else if (down) mact = 0;
    chk("move_x", 32'(pos_x), 32'(mx));
    chk("move_y", 32'(pos_y), 32'(my));
    chk("move_float", 32'(float), 32'(mm));
    chk("move_lock", 32'(lock), 32'(!ok && down));
    chk("move_active", 32'(active), 32'(mact));
    chk("move_idle", 32'(busy), 0);
    tick(1);
    chk("move_lock_once", 32'(lock), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, y19_at, lock_at;
    clear_board();
    tick(2);
    chk("rst_pos_x", 32'(pos_x), 0);
    chk("rst_pos_y", 32'(pos_y), 0);
    chk("rst_float", 32'(float), 0);
    chk("rst_chk", 32'({chk_pos_x, chk_pos_y, chk_float}), 0);
    chk("rst_flags", 32'({active, busy, lock, game_over}), 0);
    rst_n = 1'b1;
    tick(1);
    // spawn, walls on the left, cancel, rotate+left ordering
    do_spawn(16'h000F);
    chk("spawn_chk_hold", 32'(chk_float), 32'h000F);
    do_move(0);
    do_move(0);
    do_move(0);
    chk("left_wall_x", 32'(pos_x), 3);
    do_move(1);
    do_move(1);
    pulse(7'b0001100);
    chk("cancel_not_busy", 32'(busy), 0);
    tick(2);
    chk("cancel_x", 32'(pos_x), 5);
    pulse(7'b0011000);
    tick(2);
    chk("rot_first_float", 32'(float), 32'(rot_cw(16'h000F)));
    chk("rot_first_x", 32'(pos_x), 5);
    n = 0;
    while (pos_x !== 4'd4 && n < 8) begin tick(1); n++; end
    chk("rot_then_left_x", 32'(pos_x), 4);
    mx = 4; mm = rot_cw(16'h000F);
    tick(2);
    // landing on a block below, then a discarded request
    board[4][1] = 1;
    do_move(3);
    chk("land_inactive", 32'(active), 0);
    pulse(7'b0001000);
    tick(2);
    chk("after_lock_x", 32'(pos_x), 4);
    chk("after_lock_busy", 32'(busy), 0);
    // hard drop to the floor
    clear_board();
    do_spawn(16'h000F);
    pulse(7'b0100000);
    n = 1; y19_at = -1; lock_at = -1;
    while (n < 100 && lock_at < 0) begin
      if (pos_y == 5'd19 && y19_at < 0) y19_at = n;
      if (lock) lock_at = n;
      else begin tick(1); n++; end
    end
    chk("drop_y19_cycle", 32'(y19_at), 33);
    chk("drop_lock_cycle", 32'(lock_at), 35);
    chk("drop_y", 32'(pos_y), 19);
    tick(1);
    chk("drop_lock_once", 32'(lock), 0);
    mact = 0;
    // randomized play over a random rubble field
    for (int r = 10; r < 20; r++)
      for (int c = 0; c < 10; c++)
        board[r][c] = $urandom_range(0, 3) == 0;
    for (int i = 0; i < 60; i++) begin
      if (!mact) do_spawn(shapes[$urandom_range(0, 6)]);
      else do_move($urandom_range(0, 3));
    end
    // blocked spawn -> game over, sticky until reset
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    clear_board();
    for (int c = 2; c < 6; c++) board[3][c] = 1;
    spawn_mask = 16'h000F;
    pulse(7'b1000000);
    tick(2);
    chk("go_set", 32'(game_over), 1);
    chk("go_inactive", 32'(active), 0);
    clear_board();
    pulse(7'b1000000);
    chk("go_spawn_ignored", 32'(busy), 0);
    pulse(7'b0101111);
    tick(3);
    chk("go_sticky", 32'(game_over), 1);
    chk("go_pos", 32'({pos_x, pos_y}), 0);
    #2 rst_n = 1'b0;
    #1 chk("go_async_clear", 32'(game_over), 0);
    @(negedge clk) rst_n = 1'b1;
    // reset in the middle of a query
    do_spawn(16'h000F);
    pulse(7'b0001000);
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_flags", 32'({active, busy, lock}), 0);
    chk("mid_rst_chk", 32'(chk_pos_x), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(3);
    chk("mid_no_lock", 32'({lock, active}), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
